udp_rx_parser: RTL and testbench
================================

// Module: udp_rx_parser
// PURPOSE
// Consumes the same Ethernet RX byte stream as the Ethernet header cutter, one stage downstream.
// Qualifies each frame with the cutter's isIp/isNotAValidPacket flags, then parses the IPv4 and UDP headers.
// Delivers the UDP payload of frames addressed to BOARD_IP:UDP_PORT as a byte stream with first/last markers.
// Reports one ok or drop verdict per frame to the packet handler.
// PARAMETERS
// BOARD_IP     32'hC0A8000A  required IPv4 destination address (192.168.0.10)
// UDP_PORT     16'd5000      required UDP destination port
// MAX_PAYLOAD  16'd1472      largest accepted UDP payload, bytes
// PORTS
// clock          in   1   system clock; all logic on rising edge
// sclr           in   1   synchronous reset, active high
// datain         in   8   frame byte; byte 0 = first byte of destination MAC
// data_en        in   1   high for every byte of a frame, contiguous; low for >=1 cycle between frames
// is_ip          in   1   cutter isIp; sampled only in the cycle byte 14 is on datain
// is_bad         in   1   cutter isNotAValidPacket; sampled only in the cycle byte 14 is on datain
// payload_data   out  8   payload byte
// payload_valid  out  1   payload_data valid
// payload_first  out  1   with payload_valid: first payload byte
// payload_last   out  1   with payload_valid: final payload byte, per UDP length
// src_ip         out  32  sender IPv4 address of current/last accepted frame
// src_port       out  16  sender UDP port of current/last accepted frame
// payload_len    out  16  UDP length - 8 of current/last accepted frame
// frame_ok       out  1   one-cycle pulse: frame accepted and fully delivered
// frame_drop     out  1   one-cycle pulse: frame rejected
// drop_code      out  3   reason, valid with frame_drop
// BEHAVIOUR
// - Reset: all outputs 0, byte counter 0, state GAP.
// - Every output is registered; each output reflects the byte presented one cycle earlier.
// - Byte counter (11 bits) increments on each data_en cycle, saturates at 2047, and clears when data_en is low.
// - States and transitions:
//   GAP: go to IDLE when data_en=0.
//   IDLE: go to HDR when data_en=1 (byte 0).
//   HDR: bytes 0..41; step through the header checks below.
//   PAYLOAD: bytes 42..41+payload_len.
//   DROP: stay until data_en=0, then go to IDLE.
//   DONE: ignore Ethernet padding until data_en=0, then go to IDLE.
// - Header checks, evaluated on the cycle the listed byte is presented:
//   byte 14: is_ip=0 or is_bad=1 -> drop code 1 (NOT_IP); datain!=8'h45 -> code 2 (BAD_IP_HDR).
//   bytes 20-21: MF bit or fragment offset !=0 -> code 2.
//   byte 23: datain!=8'h11 -> code 3 (NOT_UDP).
//   bytes 26-29: captured as src IP; bytes 30-33 !=BOARD_IP -> code 4 (IP_MISMATCH).
//   bytes 34-35: captured as src port; bytes 36-37 !=UDP_PORT -> code 5 (PORT_MISMATCH).
//   bytes 38-39: UDP length; <8 or -8 >MAX_PAYLOAD -> code 6 (BAD_LEN), checked at byte 39.
//   IP total length and both checksums are ignored.
// - On any header failure: pulse frame_drop with drop_code next cycle, then enter DROP. Later checks in that frame are skipped.
// - data_en falls before the header or payload is complete: frame_drop with code 7 (TRUNCATED), pulsed in the cycle after data_en falls.
// - Shadow src IP/port/length copy into src_ip/src_port/payload_len together with the first payload_valid cycle, or with frame_ok for zero-length payloads. Otherwise they hold.
// - payload_len=0: no payload_valid; frame_ok pulses the cycle after byte 41.
// - Otherwise frame_ok pulses in the same cycle as payload_last.
// - Exactly one of frame_ok/frame_drop per frame that reaches byte 14 or later.
// - Frames shorter than 15 bytes produce neither pulse.
// - sclr mid-frame: outputs cleared, state GAP; the rest of that frame is ignored silently.
// - sclr has priority over all other inputs.
// TESTING
// - Valid UDP to 192.168.0.10:5000, UDP length 12, payload DE AD BE EF:
//   -> 4 payload_valid cycles, first on DE, last on EF; frame_ok with EF.
//   -> src_ip and src_port match the frame; payload_len=4.
// - ARP frame (is_ip=0 at byte 14) -> frame_drop, drop_code=1, no payload_valid.
// - Dst IP 192.168.0.11 -> drop_code=4.
// - Dst port 5001 -> drop_code=5.
// - UDP length 6 -> drop_code=6.
// - UDP length 8 plus 18 padding bytes -> frame_ok the cycle after byte 41, no payload_valid.
// - Back-to-back frames with a 1-cycle gap, second valid -> both processed correctly.
// - data_en drops after 2 of 10 payload bytes -> drop_code=7, no payload_last.
// - sclr at byte 45 -> outputs 0; no ok/drop pulse for that frame.
//   -> the next frame is parsed normally.

Source files
------------

// File: rtl/udp_rx_parser.sv
// UDP receive parser: qualifies an Ethernet frame, checks the IPv4/UDP headers
// against the board address/port and streams the UDP payload with first/last markers.
module udp_rx_parser #(
  parameter logic [31:0] BOARD_IP    = 32'hC0A8000A,
  parameter logic [15:0] UDP_PORT    = 16'd5000,
  parameter logic [15:0] MAX_PAYLOAD = 16'd1472
) (
  input  logic        clock,
  input  logic        sclr,
  input  logic [7:0]  datain,
  input  logic        data_en,
  input  logic        is_ip,
  input  logic        is_bad,
  output logic [7:0]  payload_data,
  output logic        payload_valid,
  output logic        payload_first,
  output logic        payload_last,
  output logic [31:0] src_ip,
  output logic [15:0] src_port,
  output logic [15:0] payload_len,
  output logic        frame_ok,
  output logic        frame_drop,
  output logic [2:0]  drop_code
);

  typedef enum logic [2:0] {GAP, IDLE, HDR, PAYLOAD, DROP, DONE} state_t;

  localparam logic [2:0] C_NOT_IP    = 3'd1;
  localparam logic [2:0] C_BAD_HDR   = 3'd2;
  localparam logic [2:0] C_NOT_UDP   = 3'd3;
  localparam logic [2:0] C_IP_MISM   = 3'd4;
  localparam logic [2:0] C_PORT_MISM = 3'd5;
  localparam logic [2:0] C_BAD_LEN   = 3'd6;
  localparam logic [2:0] C_TRUNC     = 3'd7;

  state_t      state;
  logic [10:0] cnt;       // index of the byte currently on datain
  logic [31:0] sh_ip;
  logic [15:0] sh_port;
  logic [15:0] sh_len;
  logic [7:0]  len_hi;
  logic [15:0] rem;
  logic [15:0] udp_len;
  logic        fail;
  logic [2:0]  code;

  assign udp_len = {len_hi, datain};

  // Header check for the byte currently presented; only meaningful in HDR.
  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    fail = 1'b0;
    code = 3'd0;
    case (cnt)
      11'd14: begin
        if (!is_ip || is_bad) begin
          fail = 1'b1; code = C_NOT_IP;
        end else if (datain != 8'h45) begin
          fail = 1'b1; code = C_BAD_HDR;
        end
      end
      11'd20: if (datain[5] || (datain[4:0] != 5'd0)) begin fail = 1'b1; code = C_BAD_HDR; end
      11'd21: if (datain != 8'h00) begin fail = 1'b1; code = C_BAD_HDR; end
      11'd23: if (datain != 8'h11) begin fail = 1'b1; code = C_NOT_UDP; end
      11'd30: if (datain != BOARD_IP[31:24]) begin fail = 1'b1; code = C_IP_MISM; end
      11'd31: if (datain != BOARD_IP[23:16]) begin fail = 1'b1; code = C_IP_MISM; end
      11'd32: if (datain != BOARD_IP[15:8])  begin fail = 1'b1; code = C_IP_MISM; end
      11'd33: if (datain != BOARD_IP[7:0])   begin fail = 1'b1; code = C_IP_MISM; end
      11'd36: if (datain != UDP_PORT[15:8])  begin fail = 1'b1; code = C_PORT_MISM; end
      11'd37: if (datain != UDP_PORT[7:0])   begin fail = 1'b1; code = C_PORT_MISM; end
      11'd39: begin
        if ((udp_len < 16'd8) || ({1'b0, udp_len} > ({1'b0, MAX_PAYLOAD} + 17'd8))) begin
          fail = 1'b1; code = C_BAD_LEN;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (sclr) begin
      state         <= GAP;
      cnt           <= '0;
      sh_ip         <= '0;
      sh_port       <= '0;
      sh_len        <= '0;
      len_hi        <= '0;
      rem           <= '0;
      payload_data  <= '0;
      payload_valid <= 1'b0;
      payload_first <= 1'b0;
      payload_last  <= 1'b0;
      src_ip        <= '0;
      src_port      <= '0;
      payload_len   <= '0;
      frame_ok      <= 1'b0;
      frame_drop    <= 1'b0;
      drop_code     <= '0;
    end else begin
      if (!data_en)             cnt <= '0;
      else if (cnt != 11'h7FF)  cnt <= cnt + 11'd1;

      payload_valid <= 1'b0;
      payload_first <= 1'b0;
      payload_last  <= 1'b0;
      frame_ok      <= 1'b0;
      frame_drop    <= 1'b0;

      case (state)
        GAP:  if (!data_en) state <= IDLE;
        IDLE: if (data_en)  state <= HDR;
        HDR: begin
          if (!data_en) begin
            // Frames that never reached byte 14 end silently.
            if (cnt > 11'd14) begin
              frame_drop <= 1'b1;
              drop_code  <= C_TRUNC;
            end
            state <= IDLE;
          end else if (fail) begin
            frame_drop <= 1'b1;
            drop_code  <= code;
            state      <= DROP;
          end else begin
            case (cnt)
              11'd26, 11'd27, 11'd28, 11'd29: sh_ip   <= {sh_ip[23:0], datain};
              11'd34, 11'd35:                 sh_port <= {sh_port[7:0], datain};
              11'd38:                         len_hi  <= datain;
              11'd39:                         sh_len  <= udp_len - 16'd8;
              11'd41: begin
                if (sh_len == 16'd0) begin
                  frame_ok    <= 1'b1;
                  src_ip      <= sh_ip;
                  src_port    <= sh_port;
                  payload_len <= 16'd0;
                  state       <= DONE;
                end else begin
                  rem   <= sh_len;
                  state <= PAYLOAD;
                end
              end
              default: ;
            endcase
          end
        end
        PAYLOAD: begin
          if (!data_en) begin
            frame_drop <= 1'b1;
            drop_code  <= C_TRUNC;
            state      <= IDLE;
          end else begin
            payload_valid <= 1'b1;
            payload_data  <= datain;
            rem           <= rem - 16'd1;
            if (cnt == 11'd42) begin
              payload_first <= 1'b1;
              src_ip        <= sh_ip;
              src_port      <= sh_port;
              payload_len   <= sh_len;
            end
            if (rem == 16'd1) begin
              payload_last <= 1'b1;
              frame_ok     <= 1'b1;
              state        <= DONE;
            end
          end
        end
        DROP, DONE: if (!data_en) state <= IDLE;
        default: state <= GAP;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_rx_parser.sv
// Directed bench for udp_rx_parser: builds frames byte by byte and checks
// payload delivery, verdict pulses and drop codes against hand-derived values.
module tb_udp_rx_parser;

  logic        clock;
  logic        sclr;
  logic [7:0]  datain;
  logic        data_en;
  logic        is_ip;
  logic        is_bad;
  logic [7:0]  payload_data;
  logic        payload_valid;
  logic        payload_first;
  logic        payload_last;
  logic [31:0] src_ip;
  logic [15:0] src_port;
  logic [15:0] payload_len;
  logic        frame_ok;
  logic        frame_drop;
  logic [2:0]  drop_code;

  udp_rx_parser dut (
    .clock(clock), .sclr(sclr), .datain(datain), .data_en(data_en),
    .is_ip(is_ip), .is_bad(is_bad),
    .payload_data(payload_data), .payload_valid(payload_valid),
    .payload_first(payload_first), .payload_last(payload_last),
    .src_ip(src_ip), .src_port(src_port), .payload_len(payload_len),
    .frame_ok(frame_ok), .frame_drop(frame_drop), .drop_code(drop_code)
  );

  localparam logic [31:0] SENDER_IP = 32'hC0A80005;
  localparam logic [31:0] GOOD_IP   = 32'hC0A8000A;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int b41_cyc = -1;

  logic [7:0] frame[$];
  logic [7:0] pl[$];

  // Monitor totals; tasks work with deltas so only this block writes them.
  int          m_valid = 0, m_first = 0, m_last = 0, m_ok = 0, m_drop = 0, m_okl = 0;
  int          m_ok_cause = -1;
  logic [2:0]  m_code = '0;
  logic [31:0] cap_ip = '0;
  logic [15:0] cap_port = '0;
  logic [15:0] cap_len = '0;
  logic [7:0]  rx[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (payload_valid) begin
      m_valid++;
      rx.push_back(payload_data);
      if (payload_first) begin
        m_first++;
        cap_ip   = src_ip;
        cap_port = src_port;
        cap_len  = payload_len;
      end
      if (payload_last) m_last++;
      if (payload_last && frame_ok) m_okl++;
    end
    if (frame_ok) begin
      m_ok++;
      m_ok_cause = cyc - 1;
    end
    if (frame_drop) begin
      m_drop++;
      m_code = drop_code;
    end
  end

  task automatic build(input logic [31:0] dip, input logic [15:0] dport, input logic [15:0] ulen,
                       input logic [7:0] proto, input logic [7:0] flags, input logic [15:0] sport,
                       input int pad);
    logic [7:0] h[42];
    h = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02,
          8'h08, 8'h00, 8'h45, 8'h00, 8'h00, 8'h2C, 8'h00, 8'h01, flags, 8'h00, 8'h40, proto,
          8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h05, dip[31:24], dip[23:16], dip[15:8], dip[7:0],
          sport[15:8], sport[7:0], dport[15:8], dport[7:0], ulen[15:8], ulen[7:0], 8'h00, 8'h00};
    frame.delete();
    for (int i = 0; i < 42; i++) frame.push_back(h[i]);
    for (int i = 0; i < pl.size(); i++) frame.push_back(pl[i]);
    for (int i = 0; i < pad; i++) frame.push_back(8'h00);
  endtask

  // Drives n bytes of frame (n<0: whole frame), then one gap cycle.
  task automatic send(input logic ip, input int n, input int sclr_at);
    int len;
    len = (n < 0 || n > frame.size()) ? frame.size() : n;
    for (int i = 0; i < len; i++) begin
      @(posedge clock); #1;
      data_en = 1'b1;
      datain  = frame[i];
      is_ip   = ip;
      is_bad  = 1'b0;
      sclr    = (i == sclr_at);
      if (i == 41) b41_cyc = cyc;
    end
    @(posedge clock); #1;
    data_en = 1'b0;
    datain  = 8'h00;
    is_ip   = 1'b0;
    sclr    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic load_deadbeef();
    pl.delete();
    pl.push_back(8'hDE); pl.push_back(8'hAD); pl.push_back(8'hBE); pl.push_back(8'hEF);
  endtask

  task automatic test_reset();
    sclr = 1'b1; data_en = 1'b0; datain = 8'h00; is_ip = 1'b0; is_bad = 1'b0;
    idle(3);
    sclr = 1'b0;
    idle(2);
    checks++; if ({payload_valid, payload_first, payload_last, frame_ok, frame_drop} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b expected 00000",
        {payload_valid, payload_first, payload_last, frame_ok, frame_drop}); end
    checks++; if (payload_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", payload_data); end
    checks++; if (src_ip !== 32'h0) begin fails++; $display("FAIL reset_src_ip: got %h expected 0", src_ip); end
    checks++; if ({src_port, payload_len} !== 32'h0) begin fails++; $display("FAIL reset_port_len: got %h expected 0", {src_port, payload_len}); end
    checks++; if (drop_code !== 3'd0) begin fails++; $display("FAIL reset_code: got %0d expected 0", drop_code); end
  endtask

  task automatic test_valid(input string tag);
    int b_valid, b_first, b_last, b_ok, b_drop, b_okl, b_rx;
    logic [7:0] exp_pl[4];
    exp_pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    b_valid = m_valid; b_first = m_first; b_last = m_last; b_ok = m_ok; b_drop = m_drop;
    b_okl = m_okl; b_rx = rx.size();
    load_deadbeef();
    build(GOOD_IP, 16'd5000, 16'd12, 8'h11, 8'h40, 16'h1234, 0);
    send(1'b1, -1, -1);
    idle(3);
    checks++; if (m_valid - b_valid !== 4) begin fails++; $display("FAIL %s valid_count: got %0d expected 4", tag, m_valid - b_valid); end
    checks++; if ((m_first - b_first !== 1) || (m_last - b_last !== 1)) begin fails++;
      $display("FAIL %s first_last_count: got %0d/%0d expected 1/1", tag, m_first - b_first, m_last - b_last); end
    checks++; if ((m_ok - b_ok !== 1) || (m_okl - b_okl !== 1)) begin fails++;
      $display("FAIL %s ok_with_last: got ok=%0d with_last=%0d expected 1/1", tag, m_ok - b_ok, m_okl - b_okl); end
    checks++; if (m_drop - b_drop !== 0) begin fails++; $display("FAIL %s no_drop: got %0d expected 0", tag, m_drop - b_drop); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx.size() < b_rx + 4 || rx[b_rx + i] !== exp_pl[i]) begin fails++;
        $display("FAIL %s payload_byte%0d: got %h expected %h", tag, i,
          (rx.size() > b_rx + i) ? rx[b_rx + i] : 8'hxx, exp_pl[i]); end
    end
    checks++; if (cap_ip !== SENDER_IP) begin fails++; $display("FAIL %s src_ip: got %h expected %h", tag, cap_ip, SENDER_IP); end
    checks++; if (cap_port !== 16'h1234) begin fails++; $display("FAIL %s src_port: got %h expected 1234", tag, cap_port); end
    checks++; if (cap_len !== 16'd4) begin fails++; $display("FAIL %s payload_len: got %0d expected 4", tag, cap_len); end
  endtask

  typedef struct {
    string       name;
    logic [31:0] dip;
    logic [15:0] dport;
    logic [15:0] ulen;
    logic        ip;
    logic [7:0]  proto;
    logic [7:0]  flags;
    int          n;
    int          ndrop;
    logic [2:0]  code;
  } drop_case_t;

  task automatic test_drops();
    drop_case_t tc[10];
    int b_drop, b_ok, b_valid;
    tc[0] = '{"arp",       GOOD_IP,      16'd5000, 16'd12,   1'b0, 8'h11, 8'h40, -1, 1, 3'd1};
    tc[1] = '{"mf_flag",   GOOD_IP,      16'd5000, 16'd12,   1'b1, 8'h11, 8'h20, -1, 1, 3'd2};
    tc[2] = '{"tcp",       GOOD_IP,      16'd5000, 16'd12,   1'b1, 8'h06, 8'h40, -1, 1, 3'd3};
    tc[3] = '{"dst_ip",    32'hC0A8000B, 16'd5000, 16'd12,   1'b1, 8'h11, 8'h40, -1, 1, 3'd4};
    tc[4] = '{"dst_port",  GOOD_IP,      16'd5001, 16'd12,   1'b1, 8'h11, 8'h40, -1, 1, 3'd5};
    tc[5] = '{"len6",      GOOD_IP,      16'd5000, 16'd6,    1'b1, 8'h11, 8'h40, -1, 1, 3'd6};
    tc[6] = '{"len1481",   GOOD_IP,      16'd5000, 16'd1481, 1'b1, 8'h11, 8'h40, -1, 1, 3'd6};
    tc[7] = '{"len1480_tr",GOOD_IP,      16'd5000, 16'd1480, 1'b1, 8'h11, 8'h40, 46, 1, 3'd7};
    tc[8] = '{"short14",   GOOD_IP,      16'd5000, 16'd12,   1'b1, 8'h11, 8'h40, 14, 0, 3'd0};
    tc[9] = '{"short15",   GOOD_IP,      16'd5000, 16'd12,   1'b1, 8'h11, 8'h40, 15, 1, 3'd7};
    for (int k = 0; k < 10; k++) begin
      b_drop = m_drop; b_ok = m_ok; b_valid = m_valid;
      load_deadbeef();
      build(tc[k].dip, tc[k].dport, tc[k].ulen, tc[k].proto, tc[k].flags, 16'h1234, 0);
      send(tc[k].ip, tc[k].n, -1);
      idle(3);
      checks++; if (m_drop - b_drop !== tc[k].ndrop) begin fails++;
        $display("FAIL %s drop_count: got %0d expected %0d", tc[k].name, m_drop - b_drop, tc[k].ndrop); end
      if (tc[k].ndrop == 1) begin
        checks++; if (m_code !== tc[k].code) begin fails++;
          $display("FAIL %s drop_code: got %0d expected %0d", tc[k].name, m_code, tc[k].code); end
      end
      checks++; if (m_ok - b_ok !== 0) begin fails++; $display("FAIL %s no_ok: got %0d expected 0", tc[k].name, m_ok - b_ok); end
      if (tc[k].n < 0) begin
        checks++; if (m_valid - b_valid !== 0) begin fails++;
          $display("FAIL %s no_payload: got %0d expected 0", tc[k].name, m_valid - b_valid); end
      end
    end
  endtask

  task automatic test_zero_len();
    int b_ok, b_valid, b_drop;
    b_ok = m_ok; b_valid = m_valid; b_drop = m_drop;
    pl.delete();
    build(GOOD_IP, 16'd5000, 16'd8, 8'h11, 8'h40, 16'h4321, 18);
    send(1'b1, -1, -1);
    idle(3);
    checks++; if ((m_ok - b_ok !== 1) || (m_drop - b_drop !== 0)) begin fails++;
      $display("FAIL zero_len_verdict: got ok=%0d drop=%0d expected 1/0", m_ok - b_ok, m_drop - b_drop); end
    checks++; if (m_ok_cause !== b41_cyc) begin fails++;
      $display("FAIL zero_len_ok_timing: got cause cycle %0d expected %0d", m_ok_cause, b41_cyc); end
    checks++; if (m_valid - b_valid !== 0) begin fails++; $display("FAIL zero_len_no_payload: got %0d expected 0", m_valid - b_valid); end
    checks++; if (payload_len !== 16'd0) begin fails++; $display("FAIL zero_len_len: got %0d expected 0", payload_len); end
    checks++; if (src_port !== 16'h4321) begin fails++; $display("FAIL zero_len_port: got %h expected 4321", src_port); end
  endtask

  task automatic test_back_to_back();
    int b_ok, b_valid, b_first, b_last, b_drop;
    b_ok = m_ok; b_valid = m_valid; b_first = m_first; b_last = m_last; b_drop = m_drop;
    load_deadbeef();
    build(GOOD_IP, 16'd5000, 16'd12, 8'h11, 8'h40, 16'h1111, 0);
    send(1'b1, -1, -1);
    pl.delete(); pl.push_back(8'h55); pl.push_back(8'hAA);
    build(GOOD_IP, 16'd5000, 16'd10, 8'h11, 8'h40, 16'h2222, 0);
    send(1'b1, -1, -1);
    idle(3);
    checks++; if (m_ok - b_ok !== 2) begin fails++; $display("FAIL b2b_ok_count: got %0d expected 2", m_ok - b_ok); end
    checks++; if (m_valid - b_valid !== 6) begin fails++; $display("FAIL b2b_valid_count: got %0d expected 6", m_valid - b_valid); end
    checks++; if ((m_first - b_first !== 2) || (m_last - b_last !== 2)) begin fails++;
      $display("FAIL b2b_first_last: got %0d/%0d expected 2/2", m_first - b_first, m_last - b_last); end
    checks++; if (m_drop - b_drop !== 0) begin fails++; $display("FAIL b2b_no_drop: got %0d expected 0", m_drop - b_drop); end
    checks++; if ({src_port, payload_len} !== {16'h2222, 16'd2}) begin fails++;
      $display("FAIL b2b_second_fields: got %h expected 22220002", {src_port, payload_len}); end
    checks++; if (rx[rx.size() - 1] !== 8'hAA) begin fails++; $display("FAIL b2b_last_byte: got %h expected aa", rx[rx.size() - 1]); end
  endtask

  task automatic test_truncated();
    int b_ok, b_valid, b_last, b_drop;
    b_ok = m_ok; b_valid = m_valid; b_last = m_last; b_drop = m_drop;
    pl.delete();
    for (int i = 0; i < 10; i++) pl.push_back(8'(8'h10 + i));
    build(GOOD_IP, 16'd5000, 16'd18, 8'h11, 8'h40, 16'h1234, 0);
    send(1'b1, 44, -1);
    idle(3);
    checks++; if ((m_drop - b_drop !== 1) || (m_code !== 3'd7)) begin fails++;
      $display("FAIL trunc_drop: got count=%0d code=%0d expected 1/7", m_drop - b_drop, m_code); end
    checks++; if (m_valid - b_valid !== 2) begin fails++; $display("FAIL trunc_valid_count: got %0d expected 2", m_valid - b_valid); end
    checks++; if ((m_last - b_last !== 0) || (m_ok - b_ok !== 0)) begin fails++;
      $display("FAIL trunc_no_last_ok: got last=%0d ok=%0d expected 0/0", m_last - b_last, m_ok - b_ok); end
  endtask

  task automatic test_sclr_mid_frame();
    int b_ok, b_drop;
    b_ok = m_ok; b_drop = m_drop;
    pl.delete();
    for (int i = 0; i < 10; i++) pl.push_back(8'(8'h30 + i));
    build(GOOD_IP, 16'd5000, 16'd18, 8'h11, 8'h40, 16'h7777, 8);
    send(1'b1, -1, 45);
    idle(3);
    checks++; if ((m_ok - b_ok !== 0) || (m_drop - b_drop !== 0)) begin fails++;
      $display("FAIL sclr_no_verdict: got ok=%0d drop=%0d expected 0/0", m_ok - b_ok, m_drop - b_drop); end
    checks++; if (src_ip !== 32'h0) begin fails++; $display("FAIL sclr_src_ip: got %h expected 0", src_ip); end
    checks++; if ({src_port, payload_len} !== 32'h0) begin fails++;
      $display("FAIL sclr_port_len: got %h expected 0", {src_port, payload_len}); end
    checks++; if ({payload_valid, frame_ok, frame_drop, drop_code} !== 6'b0) begin fails++;
      $display("FAIL sclr_flags: got %b expected 000000", {payload_valid, frame_ok, frame_drop, drop_code}); end
  endtask

  initial begin
    test_reset();
    test_valid("valid");
    test_drops();
    test_zero_len();
    test_back_to_back();
    test_truncated();
    test_sclr_mid_frame();
    test_valid("after_sclr");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
